// File: rtl/psi_pkg.sv
// Shared widths, state encoding and write-request type for the PSI register-file write path.
// The helper below orders two arrival stamps so that wrap-around is handled.
package psi_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int SEQ_W  = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Slots never sit more than a couple of cycles, so a small modular stamp
    // compared through its signed difference is enough to tell which is older.
    function automatic logic seq_older_eq(input logic [SEQ_W-1:0] a,
                                          input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] d;
        d = a - b;
        return (d == '0) || d[SEQ_W-1];
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One write-back holding slot: loads on accept, empties on grant, and a
// same-edge accept+grant replaces the drained entry (full throughput).
module wb_slot
#(
    parameter type req_t = psi_pkg::wr_req_t
)
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    accept_i,
    input  logic                    grant_i,
    input  req_t                    req_i,
    input  logic [psi_pkg::SEQ_W-1:0] seq_i,
    output logic                    vld_o,
    output req_t                    ent_o,
    output logic [psi_pkg::SEQ_W-1:0] seq_o
);

    logic                      vld_q;
    req_t                      ent_q;
    logic [psi_pkg::SEQ_W-1:0] seq_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            ent_q <= '0;
            seq_q <= '0;
        end else if (accept_i) begin
            vld_q <= 1'b1;
            ent_q <= req_i;
            seq_q <= seq_i;
        end else if (grant_i) begin
            vld_q <= 1'b0;
        end
    end

    assign vld_o = vld_q;
    assign ent_o = ent_q;
    assign seq_o = seq_q;

endmodule

// File: rtl/regfile_write_sched.sv
// Register-file write-port owner: clears every register after reset, then arbitrates ALU/load write-back.
// Accept to registered write is one edge minimum; READY depends only on slot state and grant.
module regfile_write_sched
#(
    parameter int ADDR_W    = psi_pkg::ADDR_W,
    parameter int DATA_W    = psi_pkg::DATA_W,
    parameter bit INIT_ZERO = 1'b1
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_W,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              MEM_VALID,
    input  logic [ADDR_W-1:0] MEM_W,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_READY,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] B,
    output logic              HAZ_A,
    output logic              HAZ_B,
    output logic              Write,
    output logic [ADDR_W-1:0] W,
    output logic [DATA_W-1:0] DATA,
    output logic              INIT_DONE
);

    import psi_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'((2**ADDR_W) - 1);

    state_e            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic              rr_q;
    logic [SEQ_W-1:0]  seq_q;
    logic              write_q;
    logic [ADDR_W-1:0] w_q;
    logic [DATA_W-1:0] data_q;
    logic              init_done_q;

    logic              alu_vld, mem_vld;
    wb_req_t           alu_ent, mem_ent, win_ent;
    logic [SEQ_W-1:0]  alu_seq, mem_seq;
    logic              run, contested, same_addr;
    logic              grant_alu, grant_mem, alu_acc, mem_acc;

    assign run       = (state_q == ST_RUN);
    assign contested = alu_vld && mem_vld;
    assign same_addr = (alu_ent.addr == mem_ent.addr);

    // Same-address conflicts go by age so the later write persists; equal
    // stamps favour ALU, which leaves the load value in the register.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (run) begin
            if (contested) begin
                grant_alu = same_addr ? seq_older_eq(alu_seq, mem_seq) : !rr_q;
                grant_mem = !grant_alu;
            end else begin
                grant_alu = alu_vld;
                grant_mem = mem_vld;
            end
        end
    end

    assign win_ent   = grant_alu ? alu_ent : mem_ent;
    assign ALU_READY = run && (!alu_vld || grant_alu);
    assign MEM_READY = run && (!mem_vld || grant_mem);
    assign alu_acc   = ALU_VALID && ALU_READY;
    assign mem_acc   = MEM_VALID && MEM_READY;

    wb_slot #(.req_t(wb_req_t)) u_alu_slot (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .accept_i (alu_acc),
        .grant_i  (grant_alu),
        .req_i    ({ALU_W, ALU_DATA}),
        .seq_i    (seq_q),
        .vld_o    (alu_vld),
        .ent_o    (alu_ent),
        .seq_o    (alu_seq)
    );

    wb_slot #(.req_t(wb_req_t)) u_mem_slot (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .accept_i (mem_acc),
        .grant_i  (grant_mem),
        .req_i    ({MEM_W, MEM_DATA}),
        .seq_i    (seq_q),
        .vld_o    (mem_vld),
        .ent_o    (mem_ent),
        .seq_o    (mem_seq)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= INIT_ZERO ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            seq_q       <= '0;
            write_q     <= 1'b0;
            w_q         <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            seq_q <= seq_q + 1'b1;
            case (state_q)
                ST_INIT: begin
                    write_q <= 1'b1;
                    w_q     <= cnt_q[ADDR_W-1:0];
                    data_q  <= '0;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                    write_q     <= grant_alu || grant_mem;
                    if (grant_alu || grant_mem) begin
                        w_q    <= win_ent.addr;
                        data_q <= win_ent.data;
                    end
                    // Pointer only moves on contested grants to distinct registers.
                    if (contested && !same_addr) begin
                        rr_q <= grant_alu;
                    end
                end
            endcase
        end
    end

    assign HAZ_A = !run || (alu_vld && alu_ent.addr == A) ||
                   (mem_vld && mem_ent.addr == A) || (write_q && w_q == A);
    assign HAZ_B = !run || (alu_vld && alu_ent.addr == B) ||
                   (mem_vld && mem_ent.addr == B) || (write_q && w_q == B);

    assign Write     = write_q;
    assign W         = w_q;
    assign DATA      = data_q;
    assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Randomised bench for regfile_write_sched: a transaction-level model queues expected
// register writes per cycle, and a negedge monitor pops and compares them.
module tb_regfile_write_sched;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int NREG = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ALU_VALID, MEM_VALID;
    logic [AW-1:0] ALU_W, MEM_W, A, B;
    logic [DW-1:0] ALU_DATA, MEM_DATA;
    logic          ALU_READY, MEM_READY, HAZ_A, HAZ_B;
    logic          Write, INIT_DONE;
    logic [AW-1:0] W;
    logic [DW-1:0] DATA;

    always #5 CLK = ~CLK;

    regfile_write_sched #(.ADDR_W(AW), .DATA_W(DW), .INIT_ZERO(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_W(ALU_W), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_W(MEM_W), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
        .A(A), .B(B), .HAZ_A(HAZ_A), .HAZ_B(HAZ_B),
        .Write(Write), .W(W), .DATA(DATA), .INIT_DONE(INIT_DONE)
    );

    typedef struct { int addr; int data; int cyc; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;

    // Reference model: pending requests with their arrival cycle, plus the last write.
    bit m_run, m_done, m_av, m_mv, m_rr, m_lw;
    int m_cnt, m_aa, m_ad, m_aage, m_ma, m_md, m_mage, m_lwa;

    // Driver-side requests held until the model says they were accepted.
    bit a_have, q_have;
    int a_addr, a_data, q_addr, q_data, pa, pb;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_cnt = 0; m_rr = 0; m_lw = 0; m_lwa = 0;
        m_av = 0; m_mv = 0; m_aa = 0; m_ad = 0; m_ma = 0; m_md = 0; m_aage = 0; m_mage = 0;
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_t e;
        e.addr = addr; e.data = data; e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missed_write at cycle %0d: expected W=%0h DATA=%0h at cycle %0d",
                         cyc, mon_e.addr, mon_e.data, mon_e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                chk("write_en", {31'd0, Write}, 32'd1);
                chk("write_addr", {28'd0, W}, mon_e.addr);
                chk("write_data", {24'd0, DATA}, mon_e.data);
            end else begin
                chk("write_idle", {31'd0, Write}, 32'd0);
            end
        end
    end

    task automatic step(input logic rst_v);
        bit ga, gm, era, erm, eha, ehb;
        @(negedge CLK);
        RST = rst_v;
        ALU_VALID = a_have; ALU_W = a_addr[AW-1:0]; ALU_DATA = a_data[DW-1:0];
        MEM_VALID = q_have; MEM_W = q_addr[AW-1:0]; MEM_DATA = q_data[DW-1:0];
        A = pa[AW-1:0]; B = pb[AW-1:0];
        #1;
        ga = 0; gm = 0;
        if (m_run) begin
            if (m_av && m_mv) begin
                if (m_aa == m_ma) ga = (m_aage <= m_mage);
                else              ga = (m_rr == 0);
                gm = !ga;
            end else begin
                ga = m_av; gm = m_mv;
            end
        end
        era = m_run && (!m_av || ga);
        erm = m_run && (!m_mv || gm);
        eha = !m_run || (m_av && m_aa == pa) || (m_mv && m_ma == pa) || (m_lw && m_lwa == pa);
        ehb = !m_run || (m_av && m_aa == pb) || (m_mv && m_ma == pb) || (m_lw && m_lwa == pb);
        chk("alu_ready", {31'd0, ALU_READY}, {31'd0, era});
        chk("mem_ready", {31'd0, MEM_READY}, {31'd0, erm});
        chk("haz_a", {31'd0, HAZ_A}, {31'd0, eha});
        chk("haz_b", {31'd0, HAZ_B}, {31'd0, ehb});
        chk("init_done", {31'd0, INIT_DONE}, {31'd0, m_done});
        if (!rst_v) begin
            model_reset();
            exp_q.delete();
            a_have = 0; q_have = 0;
        end else if (!m_run) begin
            push_exp(m_cnt, 0);
            m_lw = 1; m_lwa = m_cnt;
            m_cnt++;
            if (m_cnt == NREG) m_run = 1;
        end else begin
            m_done = 1;
            if (m_av && m_mv && m_aa != m_ma) m_rr = ga;
            m_lw = ga || gm;
            if (ga) begin push_exp(m_aa, m_ad); m_lwa = m_aa; m_av = 0; end
            if (gm) begin push_exp(m_ma, m_md); m_lwa = m_ma; m_mv = 0; end
            if (a_have && era) begin
                m_av = 1; m_aa = a_addr; m_ad = a_data; m_aage = cyc; a_have = 0;
            end
            if (q_have && erm) begin
                m_mv = 1; m_ma = q_addr; m_md = q_data; m_mage = cyc; q_have = 0;
            end
        end
    endtask

    task automatic set_alu(input int addr, input int data);
        a_have = 1; a_addr = addr; a_data = data;
    endtask

    task automatic set_mem(input int addr, input int data);
        q_have = 1; q_addr = addr; q_data = data;
    endtask

    initial begin
        RST = 1'b0; ALU_VALID = 0; MEM_VALID = 0; ALU_W = '0; MEM_W = '0;
        ALU_DATA = '0; MEM_DATA = '0; A = '0; B = '0;
        a_have = 0; q_have = 0; a_addr = 0; a_data = 0; q_addr = 0; q_data = 0;
        pa = 15; pb = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        mon_en = 1;
        step(1'b0);

        // Clear sequence plus the first RUN cycles.
        for (int i = 0; i < 20; i++) begin
            pa = $urandom_range(0, 15); pb = $urandom_range(0, 15);
            step(1'b1);
        end

        // Single ALU write with A probing its destination.
        pa = 3; pb = 3;
        set_alu(3, 8'h5A);
        for (int i = 0; i < 4; i++) step(1'b1);

        // Both requesters streaming to different registers.
        for (int i = 0; i < 10; i++) begin
            if (!a_have) set_alu(1, 8'h11);
            if (!q_have) set_mem(2, 8'h22);
            pa = 1; pb = 2;
            step(1'b1);
        end
        for (int i = 0; i < 4; i++) step(1'b1);

        // Same register, same accept edge.
        set_alu(7, 8'hAA); set_mem(7, 8'hBB); pa = 7;
        for (int i = 0; i < 5; i++) step(1'b1);

        // Older load entry on register 4 must win over a newer ALU entry.
        set_alu(1, 8'h01); set_mem(4, 8'h40); pa = 4;
        step(1'b1);
        set_alu(4, 8'h44);
        for (int i = 0; i < 5; i++) step(1'b1);

        // Reset while both slots hold entries, then the clear restarts at W=0.
        set_alu(5, 8'h55); set_mem(6, 8'h66);
        step(1'b1);
        set_alu(8, 8'h88); set_mem(9, 8'h99);
        step(1'b1);
        step(1'b0);
        for (int i = 0; i < 20; i++) step(1'b1);

        // Random traffic on a narrow address range to provoke conflicts.
        for (int i = 0; i < 1500; i++) begin
            if (!a_have && $urandom_range(0, 2) != 0)
                set_alu($urandom_range(0, 3), $urandom_range(0, 255));
            if (!q_have && $urandom_range(0, 2) != 0)
                set_mem($urandom_range(0, 3), $urandom_range(0, 255));
            pa = $urandom_range(0, 15); pb = $urandom_range(0, 15);
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        for (int i = 0; i < 25; i++) step(1'b1);
        @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
